// File: rtl/race_pkg.sv
// Shared encodings and default tuning values for the race game controller.
package race_pkg;

   localparam int SCORE_W = 16;

   localparam int DEF_START_LIVES   = 3;
   localparam int DEF_INVULN_FRAMES = 120;
   localparam int DEF_SCORE_DIV     = 6;
   localparam int DEF_LEVEL_PTS     = 100;
   localparam int DEF_MAX_LEVEL     = 7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      HIT  = 2'd2,
      OVER = 2'd3
   } game_state_t;

endpackage

// File: rtl/race_game_ctrl_if.sv
// Game-event inputs and HUD/sprite/enemy outputs of the race game controller.
interface race_game_ctrl_if;
   import race_pkg::*;

   logic               collision;
   logic               frame_tick;
   logic               start_btn;
   logic [1:0]         state;
   logic [1:0]         lives;
   logic [SCORE_W-1:0] score;
   logic [2:0]         speed_level;
   logic               car_visible;
   logic               enemy_respawn;
   logic               game_over;

   modport master (
      output collision, frame_tick, start_btn,
      input  state, lives, score, speed_level, car_visible, enemy_respawn, game_over
   );

   modport slave (
      input  collision, frame_tick, start_btn,
      output state, lives, score, speed_level, car_visible, enemy_respawn, game_over
   );

endinterface

// File: rtl/edge_rise_det.sv
// Registers a level and flags the cycle where it goes from 0 to 1.
module edge_rise_det (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic rise
);

   logic prev_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_reg <= 1'b0;
      end else begin
         prev_reg <= din;
      end
   end

   assign rise = din & ~prev_reg;

endmodule

// File: rtl/race_game_ctrl.sv
// Game-state controller: lives, score, speed level, post-hit invulnerability
// and enemy respawn requests, driven by collision edges and frame ticks.
module race_game_ctrl
   import race_pkg::*;
#(
   parameter int START_LIVES   = DEF_START_LIVES,
   parameter int INVULN_FRAMES = DEF_INVULN_FRAMES,
   parameter int SCORE_DIV     = DEF_SCORE_DIV,
   parameter int LEVEL_PTS     = DEF_LEVEL_PTS,
   parameter int MAX_LEVEL     = DEF_MAX_LEVEL
) (
   input logic             clk,
   input logic             rst_n,
   race_game_ctrl_if.slave bus
);

   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

   game_state_t        state_reg,       state_next;
   logic [1:0]         lives_reg,       lives_next;
   logic [SCORE_W-1:0] score_reg,       score_next;
   logic [2:0]         level_reg,       level_next;
   logic [15:0]        pts_reg,         pts_next;
   logic               level_step_reg,  level_step_next;
   logic [5:0]         div_reg,         div_next;
   logic [7:0]         inv_reg,         inv_next;
   logic               car_visible_reg, car_visible_next;
   logic               respawn_reg,     respawn_next;
   logic               over_reg,        over_next;

   logic hit;
   logic start_rise;
   logic score_wrap;
   logic [7:0] inv_dec;
   logic [7:0] inv_load;

   edge_rise_det u_col_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (bus.collision),
      .rise  (hit)
   );

   edge_rise_det u_start_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (bus.start_btn),
      .rise  (start_rise)
   );

   assign score_wrap = bus.frame_tick && (div_reg == 6'(SCORE_DIV - 1));
   assign inv_dec    = inv_reg - 8'd1;
   assign inv_load   = 8'(INVULN_FRAMES);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         lives_reg       <= 2'(START_LIVES);
         score_reg       <= '0;
         level_reg       <= '0;
         pts_reg         <= '0;
         level_step_reg  <= 1'b0;
         div_reg         <= '0;
         inv_reg         <= '0;
         car_visible_reg <= 1'b1;
         respawn_reg     <= 1'b0;
         over_reg        <= 1'b0;
      end else begin
         state_reg       <= state_next;
         lives_reg       <= lives_next;
         score_reg       <= score_next;
         level_reg       <= level_next;
         pts_reg         <= pts_next;
         level_step_reg  <= level_step_next;
         div_reg         <= div_next;
         inv_reg         <= inv_next;
         car_visible_reg <= car_visible_next;
         respawn_reg     <= respawn_next;
         over_reg        <= over_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      lives_next       = lives_reg;
      score_next       = score_reg;
      level_next       = level_reg;
      pts_next         = pts_reg;
      level_step_next  = 1'b0;
      div_next         = div_reg;
      inv_next         = inv_reg;
      car_visible_next = car_visible_reg;
      respawn_next     = 1'b0;
      over_next        = over_reg;

      // Speed level lags the score crossing by one cycle via the step flag.
      if (level_step_reg && (level_reg < 3'(MAX_LEVEL))) begin
         level_next = level_reg + 3'd1;
      end

      if ((state_reg == PLAY || state_reg == HIT) && bus.frame_tick) begin
         div_next = score_wrap ? 6'd0 : div_reg + 6'd1;
         if (score_wrap && score_reg != SCORE_MAX) begin
            score_next = score_reg + 1'b1;
            if (pts_reg == 16'(LEVEL_PTS - 1)) begin
               pts_next        = '0;
               level_step_next = 1'b1;
            end else begin
               pts_next = pts_reg + 16'd1;
            end
         end
      end

      case (state_reg)
         IDLE, OVER: begin
            if (start_rise) begin
               state_next       = PLAY;
               lives_next       = 2'(START_LIVES);
               score_next       = '0;
               level_next       = '0;
               pts_next         = '0;
               div_next         = '0;
               inv_next         = '0;
               car_visible_next = 1'b1;
               respawn_next     = 1'b1;
               over_next        = 1'b0;
            end
         end
         PLAY: begin
            if (hit) begin
               lives_next   = lives_reg - 2'd1;
               respawn_next = 1'b1;
               if (lives_reg == 2'd1) begin
                  state_next       = OVER;
                  over_next        = 1'b1;
                  car_visible_next = 1'b1;
               end else begin
                  state_next       = HIT;
                  inv_next         = inv_load;
                  car_visible_next = inv_load[2];
               end
            end
         end
         HIT: begin
            // Collisions are ignored here, including on the exit cycle.
            if (bus.frame_tick) begin
               inv_next = inv_dec;
               if (inv_dec == 8'd0) begin
                  state_next       = PLAY;
                  car_visible_next = 1'b1;
               end else begin
                  car_visible_next = inv_dec[2];
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.state         = state_reg;
   assign bus.lives         = lives_reg;
   assign bus.score         = score_reg;
   assign bus.speed_level   = level_reg;
   assign bus.car_visible   = car_visible_reg;
   assign bus.enemy_respawn = respawn_reg;
   assign bus.game_over     = over_reg;

endmodule

// File: tb/tb_race_game_ctrl.sv
// Randomised scoreboard bench for race_game_ctrl against a frame-level game model.
module tb_race_game_ctrl;
   import race_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   race_game_ctrl_if bus ();

   race_game_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int st;
      int lv;
      int sc;
      int spd;
      int vis;
      int rsp;
      int ovr;
   } snap_t;

   snap_t exp_q[$];
   int errors = 0;
   int checks = 0;
   int resp_seen = 0;

   // Game model state (plain integers, rules stated per game phase)
   int m_state, m_lives, m_score, m_level, m_div, m_inv, m_vis, m_resp;
   bit m_col_q, m_start_q;

   function automatic int lvl_of(int s);
      int l;
      l = s / DEF_LEVEL_PTS;
      return (l > DEF_MAX_LEVEL) ? DEF_MAX_LEVEL : l;
   endfunction

   function automatic void model_reset();
      m_state = 0; m_lives = DEF_START_LIVES; m_score = 0; m_level = 0;
      m_div = 0; m_inv = 0; m_vis = 1; m_resp = 0;
      m_col_q = 1'b0; m_start_q = 1'b0;
   endfunction

   function automatic void model_step(bit c, bit f, bit s);
      bit hit, sr;
      int old_score;
      snap_t e;
      hit = c && !m_col_q;
      sr  = s && !m_start_q;
      m_col_q = c;
      m_start_q = s;
      old_score = m_score;
      m_resp = 0;
      if (m_state == 0 || m_state == 3) begin
         if (sr) begin
            m_state = 1; m_lives = DEF_START_LIVES; m_score = 0; m_level = 0;
            m_div = 0; m_resp = 1; m_vis = 1;
         end else begin
            m_level = lvl_of(old_score);
         end
      end else begin
         m_level = lvl_of(old_score);
         if (f) begin
            if (m_div == DEF_SCORE_DIV - 1) begin
               m_div = 0;
               if (m_score < 65535) m_score++;
            end else begin
               m_div++;
            end
         end
         if (m_state == 1) begin
            if (hit) begin
               m_resp = 1;
               m_lives--;
               if (m_lives == 0) begin
                  m_state = 3; m_vis = 1;
               end else begin
                  m_state = 2; m_inv = DEF_INVULN_FRAMES; m_vis = (m_inv >> 2) & 1;
               end
            end
         end else if (f) begin
            m_inv--;
            if (m_inv == 0) begin
               m_state = 1; m_vis = 1;
            end else begin
               m_vis = (m_inv >> 2) & 1;
            end
         end
      end
      e.st = m_state; e.lv = m_lives; e.sc = m_score; e.spd = m_level;
      e.vis = m_vis; e.rsp = m_resp; e.ovr = (m_state == 3) ? 1 : 0;
      exp_q.push_back(e);
   endfunction

   task automatic check_eq(string name, int got, int expv);
      checks++;
      if (got != expv) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, got, expv);
      end
   endtask

   // One stimulus cycle: inputs change mid-cycle, expectation queued for the next edge
   task automatic step(bit c, bit f, bit s);
      @(negedge clk);
      #1;
      bus.collision  = c;
      bus.frame_tick = f;
      bus.start_btn  = s;
      model_step(c, f, s);
      @(posedge clk);
   endtask

   task automatic ticks(int n);
      for (int i = 0; i < n; i++) begin
         step(1'b0, 1'b1, 1'b0);
         repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic finish_hit();
      int n;
      n = 0;
      while (m_state == 2 && n < 2000) begin
         step(1'b0, 1'b1, 1'b0);
         n++;
      end
      checks++;
      if (m_state == 2) begin
         errors++;
         $display("FAIL hit_timeout: got state %0d, expected 1", m_state);
      end
   endtask

   // Monitor: every clock the DUT presents a fresh registered output set
   always @(negedge clk) begin
      snap_t e;
      if (rst_n && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (bus.enemy_respawn) begin
            resp_seen++;
            $display("respawn t=%0t lives=%0d score=%0d", $time, bus.lives, bus.score);
         end
         checks++;
         if (int'(bus.state) != e.st || int'(bus.lives) != e.lv || int'(bus.score) != e.sc ||
             int'(bus.speed_level) != e.spd || int'(bus.car_visible) != e.vis ||
             int'(bus.enemy_respawn) != e.rsp || int'(bus.game_over) != e.ovr) begin
            errors++;
            $display("FAIL cycle t=%0t got st=%0d lv=%0d sc=%0d spd=%0d vis=%0d rsp=%0d ovr=%0d, expected st=%0d lv=%0d sc=%0d spd=%0d vis=%0d rsp=%0d ovr=%0d",
                     $time, bus.state, bus.lives, bus.score, bus.speed_level, bus.car_visible,
                     bus.enemy_respawn, bus.game_over, e.st, e.lv, e.sc, e.spd, e.vis, e.rsp, e.ovr);
         end
      end
   end

   task automatic check_reset_values(string tag);
      check_eq({tag, "_state"}, int'(bus.state), 0);
      check_eq({tag, "_lives"}, int'(bus.lives), DEF_START_LIVES);
      check_eq({tag, "_score"}, int'(bus.score), 0);
      check_eq({tag, "_speed"}, int'(bus.speed_level), 0);
      check_eq({tag, "_vis"}, int'(bus.car_visible), 1);
      check_eq({tag, "_respawn"}, int'(bus.enemy_respawn), 0);
      check_eq({tag, "_over"}, int'(bus.game_over), 0);
   endtask

   initial begin
      int r0;
      int frozen;
      int n;
      bus.collision = 1'b0;
      bus.frame_tick = 1'b0;
      bus.start_btn = 1'b0;
      model_reset();
      #12;
      check_reset_values("reset");
      #11;
      rst_n = 1'b1;
      step(0, 0, 0);
      step(0, 0, 0);

      // Start: held button gives exactly one respawn pulse
      r0 = resp_seen;
      repeat (6) step(0, 0, 1);
      step(0, 0, 0);
      @(negedge clk); #1;
      check_eq("start_respawn_count", resp_seen - r0, 1);
      check_eq("start_state", int'(bus.state), 1);
      check_eq("start_lives", int'(bus.lives), 3);
      check_eq("start_score", int'(bus.score), 0);

      // Scoring and speed level
      ticks(600);
      step(0, 0, 0);
      @(negedge clk); #1;
      check_eq("score_600", int'(bus.score), 100);
      check_eq("speed_600", int'(bus.speed_level), 1);
      ticks(3600);
      step(0, 0, 0);
      @(negedge clk); #1;
      check_eq("score_4200", int'(bus.score), 700);
      check_eq("speed_4200", int'(bus.speed_level), 7);
      ticks(600);
      step(0, 0, 0);
      @(negedge clk); #1;
      check_eq("score_4800", int'(bus.score), 800);
      check_eq("speed_sat", int'(bus.speed_level), 7);

      // Collision held high: one hit only
      r0 = resp_seen;
      repeat (500) step(1, 0, 0);
      step(0, 0, 0);
      @(negedge clk); #1;
      check_eq("hold_lives", int'(bus.lives), 2);
      check_eq("hold_state", int'(bus.state), 2);
      check_eq("hold_respawn_count", resp_seen - r0, 1);

      // Invulnerability: random collision edges ignored, blink tracked per cycle
      n = 0;
      while (m_state == 2 && n < 5000) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
         n++;
      end
      step(0, 0, 0);
      @(negedge clk); #1;
      check_eq("invuln_exit_state", int'(bus.state), 1);
      check_eq("invuln_exit_vis", int'(bus.car_visible), 1);
      check_eq("invuln_lives", int'(bus.lives), 2);

      // Two more hits -> game over
      step(1, 0, 0); step(0, 0, 0);
      finish_hit();
      step(1, 0, 0); step(0, 0, 0);
      @(negedge clk); #1;
      check_eq("over_state", int'(bus.state), 3);
      check_eq("over_lives", int'(bus.lives), 0);
      check_eq("over_flag", int'(bus.game_over), 1);
      frozen = m_score;
      for (int i = 0; i < 50; i++) step(1'($urandom_range(0, 1)), 1'b1, 1'b0);
      step(0, 0, 0);
      @(negedge clk); #1;
      check_eq("over_score_frozen", int'(bus.score), frozen);
      step(0, 0, 1);
      step(0, 0, 0);
      @(negedge clk); #1;
      check_eq("restart_state", int'(bus.state), 1);
      check_eq("restart_lives", int'(bus.lives), 3);
      check_eq("restart_score", int'(bus.score), 0);

      // Hit coinciding with the score-wrap tick
      repeat (5) step(0, 1, 0);
      step(1, 1, 0);
      #1;
      check_eq("simul_score", int'(bus.score), 1);
      check_eq("simul_lives", int'(bus.lives), 2);
      repeat (10) step(0, 1, 0);

      // Asynchronous reset mid-HIT, between clock edges
      @(negedge clk); #1;
      check_eq("prereset_state", int'(bus.state), 2);
      rst_n = 1'b0;
      #1;
      check_reset_values("async");
      model_reset();
      #1;
      rst_n = 1'b1;

      // Random play, including restarts after game over
      step(0, 0, 1);
      for (int i = 0; i < 4000; i++) begin
         step(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 63) == 0));
      end
      repeat (3) step(0, 0, 0);
      @(negedge clk); #1;
      check_eq("queue_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
